// File: rtl/param_cpu_pkg.sv
// Shared types and field-layout helpers for the param_cpu core.
// Opcodes, ALU function codes, FSM states and instruction field offsets.
package param_cpu_pkg;

    typedef enum logic [1:0] {
        ADDI    = 2'd0,
        ALU     = 2'd1,
        LOAD_R  = 2'd2,
        STORE_R = 2'd3
    } opcode_e;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] AND = 4'd2;
    localparam logic [3:0] OR  = 4'd3;
    localparam logic [3:0] XOR = 4'd4;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_e;

    function automatic int func_lsb();
        return 0;
    endfunction

    function automatic int off_lsb();
        return 4;
    endfunction

    function automatic int x3_lsb(input int dw);
        return dw + 4;
    endfunction

    function automatic int x2_lsb(input int rb, input int dw);
        return rb + dw + 4;
    endfunction

    function automatic int x1_lsb(input int rb, input int dw);
        return 2 * rb + dw + 4;
    endfunction

    function automatic int op_lsb(input int rb, input int dw);
        return 3 * rb + dw + 4;
    endfunction

    function automatic int instr_width(input int rb, input int dw);
        return 2 + 3 * rb + dw + 4;
    endfunction

endpackage

// File: rtl/param_cpu_alu.sv
// Combinational ALU for param_cpu: ADD/SUB with carry/borrow, AND/OR/XOR.
// Function codes above XOR produce zero and are treated as NOP by the core.
module param_cpu_alu
    import param_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            func,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  zero
);

    logic [DATA_WIDTH:0] wide;

    // One extra bit holds carry (ADD) or borrow (SUB); logic ops clear it
    always_comb begin
        wide = '0;
        case (func)
            ADD:     wide = {1'b0, a} + {1'b0, b};
            SUB:     wide = {1'b0, a} - {1'b0, b};
            AND:     wide = {1'b0, a & b};
            OR:      wide = {1'b0, a | b};
            XOR:     wide = {1'b0, a ^ b};
            default: wide = '0;
        endcase
    end

    assign result = wide[DATA_WIDTH-1:0];
    assign carry  = wide[DATA_WIDTH];
    assign zero   = (result == '0);

endmodule

// File: rtl/param_cpu.sv
// Multi-cycle load/store core with valid/ready instruction intake.
// Define PARAM_CPU_DBG_PORT_EN to expose the dbg_sel/dbg_data register read port.
module param_cpu
    import param_cpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 5,
    parameter int REG_BITS    = 2,
    parameter int INSTR_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    output logic                   retire,
    output logic                   flag_z,
    output logic                   flag_c
`ifdef PARAM_CPU_DBG_PORT_EN
    ,
    input  logic [REG_BITS-1:0]    dbg_sel,
    output logic [DATA_WIDTH-1:0]  dbg_data
`endif
);

    localparam int NREG = 2 ** REG_BITS;
    localparam int NMEM = 2 ** ADDR_BITS;
    localparam int OP_L = op_lsb(REG_BITS, DATA_WIDTH);
    localparam int X1_L = x1_lsb(REG_BITS, DATA_WIDTH);
    localparam int X2_L = x2_lsb(REG_BITS, DATA_WIDTH);
    localparam int X3_L = x3_lsb(DATA_WIDTH);
    localparam int OF_L = off_lsb();
    localparam int FN_L = func_lsb();

    if (INSTR_WIDTH != instr_width(REG_BITS, DATA_WIDTH)) begin : g_width_chk
        $error("param_cpu: INSTR_WIDTH must equal 2+3*REG_BITS+DATA_WIDTH+4");
    end

    state_e state, state_nx;

    logic [INSTR_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0]  regs [NREG];
    logic [DATA_WIDTH-1:0]  dmem [NMEM];
    logic [DATA_WIDTH-1:0]  opd1, opd2, opd3, res;
    logic [ADDR_BITS-1:0]   addr;
    logic                   res_c, res_z;

    opcode_e               op;
    logic [REG_BITS-1:0]   x1, x2, x3;
    logic [DATA_WIDTH-1:0] off;
    logic [3:0]            fn;
    logic                  fn_ok;

    assign op    = opcode_e'(ir[OP_L +: 2]);
    assign x1    = ir[X1_L +: REG_BITS];
    assign x2    = ir[X2_L +: REG_BITS];
    assign x3    = ir[X3_L +: REG_BITS];
    assign off   = ir[OF_L +: DATA_WIDTH];
    assign fn    = ir[FN_L +: 4];
    assign fn_ok = (fn <= XOR);

    logic [DATA_WIDTH-1:0] alu_b, alu_res;
    logic [3:0]            alu_fn;
    logic                  alu_c, alu_z;
    logic [DATA_WIDTH:0]   addr_sum;

    assign alu_b    = (op == ADDI) ? off : opd3;
    assign alu_fn   = (op == ADDI) ? ADD : fn;
    assign addr_sum = {1'b0, opd2} + {1'b0, off};

    param_cpu_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .a     (opd2),
        .b     (alu_b),
        .func  (alu_fn),
        .result(alu_res),
        .carry (alu_c),
        .zero  (alu_z)
    );

    assign instr_ready = (state == IDLE);

    // State register; reset wins over any in-flight instruction
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: memory ops detour through MEM, STORE retires from there
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (instr_valid) state_nx = DECODE;
            DECODE:  state_nx = EXEC;
            EXEC:    state_nx = (op == LOAD_R || op == STORE_R) ? MEM : WB;
            MEM:     state_nx = (op == LOAD_R) ? WB : IDLE;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Retire pulses for the cycle after the completing edge
    always_ff @(posedge clk) begin
        if (rst) retire <= 1'b0;
        else     retire <= (state == WB) || (state == MEM && op == STORE_R);
    end

    // Per-instruction working registers; no reset needed, IDLE gates them
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && instr_valid) ir <= instruction;
        if (state == DECODE) begin
            opd1 <= regs[x1];
            opd2 <= regs[x2];
            opd3 <= regs[x3];
        end
        if (state == EXEC) begin
            res   <= alu_res;
            res_c <= alu_c;
            res_z <= alu_z;
            addr  <= ADDR_BITS'(addr_sum);
        end
        if (state == MEM && op == LOAD_R) res <= dmem[addr];
    end

    // Architectural state: register file, data memory and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= DATA_WIDTH'(i);
            for (int i = 0; i < NMEM; i++) dmem[i] <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            if (state == MEM && op == STORE_R) dmem[addr] <= opd1;
            if (state == WB) begin
                if (op != ALU || fn_ok) regs[x1] <= res;
                if (op == ADDI || (op == ALU && fn_ok)) begin
                    flag_z <= res_z;
                    flag_c <= res_c;
                end
            end
        end
    end

`ifdef PARAM_CPU_DBG_PORT_EN
    assign dbg_data = regs[dbg_sel];
`else
`endif

endmodule

// File: tb/tb_param_cpu.sv
// Randomised self-checking bench for param_cpu at default parameters.
// Compares architectural state against an arithmetic reference model.
module tb_param_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic [19:0] instruction = '0;
    logic        instr_ready, retire, flag_z, flag_c;
`ifdef PARAM_CPU_DBG_PORT_EN
    logic [1:0]  dbg_sel = '0;
    logic [7:0]  dbg_data;
`endif

    param_cpu dut (
        .clk        (clk),
        .rst        (rst),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .retire     (retire),
        .flag_z     (flag_z),
        .flag_c     (flag_c)
`ifdef PARAM_CPU_DBG_PORT_EN
        ,
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int m_reg [4];
    int m_mem [32];
    int m_z, m_c;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] mk(input int op, input int x1, input int x2,
                                       input int x3, input int off, input int fn);
        return {op[1:0], x1[1:0], x2[1:0], x3[1:0], off[7:0], fn[3:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = i;
        for (int i = 0; i < 32; i++) m_mem[i] = 0;
        m_z = 0;
        m_c = 0;
    endtask

    task automatic model_apply(input logic [19:0] ins);
        int op, x1, x2, x3, off, fn, a, b, r, ad;
        op  = int'(ins[19:18]);
        x1  = int'(ins[17:16]);
        x2  = int'(ins[15:14]);
        x3  = int'(ins[13:12]);
        off = int'(ins[11:4]);
        fn  = int'(ins[3:0]);
        a   = m_reg[x2];
        b   = m_reg[x3];
        ad  = (a + off) % 32;
        case (op)
            0: begin
                r = a + off;
                m_c = (r > 255) ? 1 : 0;
                r = r % 256;
                m_reg[x1] = r;
                m_z = (r == 0) ? 1 : 0;
            end
            1: if (fn <= 4) begin
                m_c = 0;
                case (fn)
                    0: begin r = a + b; m_c = (r > 255) ? 1 : 0; end
                    1: begin r = a - b + 256; m_c = (a < b) ? 1 : 0; end
                    2: r = a & b;
                    3: r = a | b;
                    default: r = a ^ b;
                endcase
                r = r % 256;
                m_reg[x1] = r;
                m_z = (r == 0) ? 1 : 0;
            end
            2: m_reg[x1] = m_mem[ad];
            default: m_mem[ad] = m_reg[x1];
        endcase
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_r%0d", tag, i), 32'(dut.regs[i]), m_reg[i]);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_m%0d", tag, i), 32'(dut.dmem[i]), m_mem[i]);
        check({tag, "_z"}, 32'(flag_z), m_z);
        check({tag, "_c"}, 32'(flag_c), m_c);
    endtask

    task automatic run(input logic [19:0] ins);
        int k;
        int lat;
        lat = (ins[19:18] == 2'b10) ? 4 : 3;
        check("ready_in", 32'(instr_ready), 1);
        instruction = ins;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instruction = 20'($urandom);
        k = 0;
        while (!retire && k < 8) begin
            tick();
            k++;
            if (k == 1) check("busy", 32'(instr_ready), 0);
        end
        check("lat", k, lat);
        model_apply(ins);
        compare_all("st");
    endtask

    logic [19:0] q [3];
    int t [3];
    int idx, cyc, lows, t_rdy;
    logic acc;

    initial begin
        model_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(instr_ready), 1);
        check("rst_retire", 32'(retire), 0);
        compare_all("rst");
`ifdef PARAM_CPU_DBG_PORT_EN
        dbg_sel = 2'd3;
        #1;
        check("dbg", 32'(dbg_data), 3);
`endif

        run(20'b01000111000000000000);
        check("add_r0", 32'(dut.regs[0]), 4);
        check("add_z", 32'(flag_z), 0);
        check("add_c", 32'(flag_c), 0);
        check("retire_hi", 32'(retire), 1);
        tick();
        check("retire_pulse", 32'(retire), 0);
        run(mk(1, 1, 0, 3, 0, 0));
        check("add_r1", 32'(dut.regs[1]), 7);
        run(mk(1, 3, 0, 2, 0, 1));
        check("sub_r3", 32'(dut.regs[3]), 2);
        run(mk(1, 0, 2, 3, 0, 1));
        check("sub_r0", 32'(dut.regs[0]), 0);
        check("sub_z", 32'(flag_z), 1);
        run(mk(3, 1, 2, 0, 15, 0));
        check("store17", 32'(dut.dmem[17]), 7);
        run(mk(2, 3, 2, 0, 15, 0));
        check("load_r3", 32'(dut.regs[3]), 7);
        run(mk(3, 1, 2, 0, 31, 0));
        check("wrap_m1", 32'(dut.dmem[1]), 7);
        run(mk(0, 0, 3, 0, 255, 0));
        check("addi_r0", 32'(dut.regs[0]), 6);
        check("addi_c", 32'(flag_c), 1);
        run(mk(1, 0, 0, 0, 0, 0));
        check("self_r0", 32'(dut.regs[0]), 12);

        q[0] = mk(1, 2, 2, 2, 0, 0);
        q[1] = mk(3, 1, 2, 0, 3, 0);
        q[2] = mk(2, 0, 2, 0, 3, 0);
        idx = 0;
        cyc = 0;
        lows = 0;
        t_rdy = -1;
        instr_valid = 1'b1;
        instruction = q[0];
        while (t_rdy < 0 && cyc < 60) begin
            acc = instr_ready;
            if (!acc) lows++;
            tick();
            cyc++;
            if (acc) begin
                if (idx < 3) begin
                    t[idx] = cyc;
                    model_apply(q[idx]);
                    idx++;
                    if (idx < 3) instruction = q[idx];
                    else instr_valid = 1'b0;
                end else begin
                    t_rdy = cyc;
                end
            end
        end
        instr_valid = 1'b0;
        check("b2b_done", 32'(t_rdy >= 0), 1);
        check("b2b_gap0", t[1] - t[0], 4);
        check("b2b_gap1", t[2] - t[1], 4);
        check("b2b_gap2", t_rdy - t[2], 5);
        check("b2b_busy", lows, 10);
        compare_all("b2b");

        instruction = mk(3, 1, 2, 0, 5, 0);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("abort_ready", 32'(instr_ready), 1);
        check("abort_retire", 32'(retire), 0);
        check("abort_mem", 32'(dut.dmem[9]), 0);
        compare_all("abort");
`ifdef PARAM_CPU_DBG_PORT_EN
        dbg_sel = 2'd3;
        #1;
        check("abort_dbg", 32'(dbg_data), 3);
`endif

        rst = 1'b1;
        instr_valid = 1'b1;
        instruction = mk(0, 0, 1, 0, 9, 0);
        tick();
        rst = 1'b0;
        instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rstv_retire", 32'(retire), 0);
            tick();
        end
        compare_all("rstv");

        for (int i = 0; i < 60; i++) begin
            run(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), int'($urandom_range(0, 255)),
                   $urandom_range(0, 6)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
